// File: rtl/ahb_lite_master_pkg.sv
// Shared AHB-Lite encodings, master FSM states and the 1 KB boundary helper.
package ahb_lite_master_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_BURST,
    ST_LAST
  } state_t;

  function automatic logic crosses_1kb(input logic [9:0] off, input logic [2:0] size,
                                       input logic [15:0] beats_m1);
    logic [23:0] bytes;
    bytes = (24'(beats_m1) + 24'd1) << size;
    return (24'(off) + bytes) > 24'd1024;
  endfunction

endpackage

// File: rtl/ahb_master_addr_gen.sv
// Beat address register with size-based increment and remaining-beat down-counter.
module ahb_master_addr_gen
  import ahb_lite_master_pkg::*;
#(
  parameter int AW    = 32,
  parameter int LEN_W = 4
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             load,
  input  logic             skip_first,
  input  logic             step,
  input  logic [AW-1:0]    ld_addr,
  input  logic [2:0]       ld_size,
  input  logic [LEN_W-1:0] ld_len,
  output logic [AW-1:0]    addr,
  output logic             last
);

  logic [2:0]       size_r;
  logic [LEN_W-1:0] cnt;
  logic [AW-1:0]    ld_inc;
  logic [AW-1:0]    inc;

  assign ld_inc = AW'(1) << ld_size;
  assign inc    = AW'(1) << size_r;
  // addr is the next beat still to be issued; last flags that it is the final one
  assign last   = (cnt == '0);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr   <= '0;
      cnt    <= '0;
      size_r <= '0;
    end else if (load) begin
      size_r <= ld_size;
      if (skip_first) begin
        addr <= ld_addr + ld_inc;
        cnt  <= ld_len - LEN_W'(1);
      end else begin
        addr <= ld_addr;
        cnt  <= ld_len;
      end
    end else if (step) begin
      addr <= addr + inc;
      cnt  <= cnt - LEN_W'(1);
    end
  end

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: command/stream interface to SINGLE/INCR bursts of 1..2**LEN_W beats.
// Define AHB_MASTER_ERR_ABORT_EN to cancel the remaining beats on the first ERROR response.
module ahb_lite_master
  import ahb_lite_master_pkg::*;
#(
  parameter int AW    = 32,
  parameter int LEN_W = 4
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [2:0]       cmd_size,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      wdata,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  output logic [31:0]      rdata,
  output logic             rdata_valid,
  output logic             done,
  output logic             err,
  output logic [AW-1:0]    HADDR,
  output logic [1:0]       HTRANS,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic             HWRITE,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP
);

  state_t        state;
  htrans_t       htrans_q;
  logic          wr_r;
  logic          err_r;
  logic          dph_valid;
  logic [31:0]   wbuf;
  logic          bus_active;
  logic          acc;
  logic          acc_issue;
  logic          issue_ok;
  logic          err_cycle;
  logic [AW-1:0] gen_addr;
  logic          gen_last;

  assign HTRANS     = htrans_q;
  assign bus_active = (htrans_q == HTRANS_NONSEQ) || (htrans_q == HTRANS_SEQ);
  assign acc        = HRESETn && cmd_ready && cmd_valid;
  assign acc_issue  = acc && HREADY && (!cmd_write || wdata_valid);
  assign issue_ok   = HREADY && ((state == ST_ADDR) || (state == ST_BURST)) && (!wr_r || wdata_valid);
  assign err_cycle  = dph_valid && !HREADY && (HRESP == HRESP_ERROR);
  // write beats are pulled when their address is issued and parked in wbuf until the data phase
  assign wdata_ready = (acc_issue && cmd_write) || (issue_ok && wr_r);
  assign rdata       = HRDATA;
  assign rdata_valid = dph_valid && !HWRITE && HREADY && (HRESP == HRESP_OKAY);

  ahb_master_addr_gen #(.AW(AW), .LEN_W(LEN_W)) u_addr_gen (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .load       (acc),
    .skip_first (acc_issue),
    .step       (issue_ok),
    .ld_addr    (cmd_addr),
    .ld_size    (cmd_size),
    .ld_len     (cmd_len),
    .addr       (gen_addr),
    .last       (gen_last)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      htrans_q  <= HTRANS_IDLE;
      HADDR     <= '0;
      HSIZE     <= HSIZE_BYTE;
      HBURST    <= HBURST_SINGLE;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      err_r     <= 1'b0;
      wr_r      <= 1'b0;
      dph_valid <= 1'b0;
      wbuf      <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (err_cycle) err_r <= 1'b1;
      if (HREADY) begin
        dph_valid <= bus_active;
        if (bus_active && HWRITE) HWDATA <= wbuf;
      end
      if (wdata_ready) wbuf <= wdata;
      unique case (state)
        ST_IDLE: begin
          if (acc) begin
            cmd_ready <= 1'b0;
            err_r     <= 1'b0;
            wr_r      <= cmd_write;
            HWRITE    <= cmd_write;
            HSIZE     <= cmd_size;
            HBURST    <= (cmd_len == '0) ? HBURST_SINGLE : HBURST_INCR;
            HADDR     <= cmd_addr;
            if (acc_issue) begin
              htrans_q <= HTRANS_NONSEQ;
              state    <= (cmd_len == '0) ? ST_LAST : ST_BURST;
            end else begin
              state <= ST_ADDR;
            end
          end
        end
        ST_ADDR, ST_BURST: begin
`ifdef AHB_MASTER_ERR_ABORT_EN
          if (err_cycle) begin
            htrans_q <= HTRANS_IDLE;
            state    <= ST_LAST;
          end else
`endif
          if (HREADY) begin
            HADDR <= gen_addr;
            if (issue_ok) begin
              htrans_q <= (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_SEQ;
              state    <= gen_last ? ST_LAST : ST_BURST;
            end else begin
              htrans_q <= (state == ST_ADDR) ? HTRANS_IDLE : HTRANS_BUSY;
            end
          end
        end
        ST_LAST: begin
`ifdef AHB_MASTER_ERR_ABORT_EN
          if (err_cycle) htrans_q <= HTRANS_IDLE;
`endif
          if (HREADY) begin
            if (bus_active) begin
              htrans_q <= HTRANS_IDLE;
            end else if (dph_valid) begin
              state     <= ST_IDLE;
              cmd_ready <= 1'b1;
              done      <= 1'b1;
              err       <= err_r;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (acc) assert (!crosses_1kb(cmd_addr[9:0], cmd_size, 16'(cmd_len)));
  end

endmodule
